// File: rtl/ram_line_responder.sv
// rtl/ram_line_responder.sv - far-end RAM responder for cache line fills and write-backs
// One request in flight; completes after LATENCY cycles with a one-cycle data_ready_m pulse.
module ram_line_responder #(
  parameter int ADDR_W  = 46,
  parameter int DEPTH_W = 10,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_line,
  output logic              req_ready,
  output logic [LINE_W-1:0] line_out,
  output logic              data_ready_m,
  output logic              busy
);

  localparam int         LINES = 1 << DEPTH_W;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [DEPTH_W-1:0]  idx_q;
  logic [LINE_W-1:0]   wline_q;
  logic [LINES-1:0]    valid_q;
  logic [LINE_W-1:0]   line_out_q;
  logic [LINE_W-1:0]   mem [LINES];
  logic                accept;
  logic                commit;

  // Upper address bits alias onto the same line on purpose.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      valid_q    <= '0;
      line_out_q <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wline_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[DEPTH_W-1:0];
        wline_q <= req_line;
      end
      if (commit && we_q) begin
        valid_q[idx_q] <= 1'b1;
      end
      if (commit && !we_q) begin
        line_out_q <= valid_q[idx_q] ? mem[idx_q] : '0;
      end
    end
  end

  // Data array has no reset; the valid bits alone decide what a read returns.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[idx_q] <= wline_q;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign data_ready_m = (state_q == S_RESP);
  assign line_out     = line_out_q;

endmodule

// File: tb/tb_ram_line_responder.sv
// tb/tb_ram_line_responder.sv - bench for ram_line_responder (LATENCY=4 and LATENCY=1 instances)
module tb_ram_line_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  bit          sel;
  logic        req_we;
  logic [45:0] req_addr;
  logic [63:0] req_line;

  logic        req_a, req_b;
  logic        rr_a, rr_b, dr_a, dr_b, busy_a, busy_b;
  logic [63:0] lo_a, lo_b;
  logic        rdy_s, dr_s, busy_s;
  logic [63:0] lo_s;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc0[$];
  int acc1[$];
  logic [63:0] mem_m [int];
  logic [63:0] lo_m [2];

  typedef struct {
    bit          we;
    logic [45:0] addr;
    logic [63:0] line;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  assign req_a  = req & ~sel;
  assign req_b  = req & sel;
  assign rdy_s  = sel ? rr_b : rr_a;
  assign dr_s   = sel ? dr_b : dr_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign lo_s   = sel ? lo_b : lo_a;

  ram_line_responder #(.LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .req_we(req_we), .req_addr(req_addr),
    .req_line(req_line), .req_ready(rr_a), .line_out(lo_a), .data_ready_m(dr_a), .busy(busy_a)
  );

  ram_line_responder #(.LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_we(req_we), .req_addr(req_addr),
    .req_line(req_line), .req_ready(rr_b), .line_out(lo_b), .data_ready_m(dr_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (req_a && rr_a) acc0.push_back(cyc);
    if (req_b && rr_b) acc1.push_back(cyc);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int key(input int s, input logic [45:0] a);
    return s * 4096 + int'(a[9:0]);
  endfunction

  function automatic logic [63:0] model_read(input int s, input logic [45:0] a);
    if (mem_m.exists(key(s, a))) return mem_m[key(s, a)];
    return 64'd0;
  endfunction

  function automatic int acc_count(input int s);
    return (s == 0) ? acc0.size() : acc1.size();
  endfunction

  function automatic int acc_at(input int s, input int i);
    return (s == 0) ? acc0[i] : acc1[i];
  endfunction

  task automatic do_req(input int s, input bit we, input logic [45:0] addr,
                        input logic [63:0] line, output logic [63:0] got);
    int n;
    int lat;
    @(negedge clk);
    sel = (s != 0);
    req_we = we; req_addr = addr; req_line = line; req = 1'b1;
    n = 0;
    while (!rdy_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_s) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req = 1'b0;
      got = lo_s;
      return;
    end
    @(posedge clk); #1;
    req = 1'b0; req_we = ~we; req_addr = ~addr; req_line = ~line;
    chk("busy_after_accept", 64'(busy_s), 64'd1);
    chk("ready_after_accept", 64'(rdy_s), 64'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dr_s) break;
    end
    chk("latency", 64'(lat), (s != 0) ? 64'd1 : 64'd4);
    if (we) mem_m[key(s, addr)] = line;
    else lo_m[s] = model_read(s, addr);
    chk("line_out", lo_s, lo_m[s]);
    got = lo_s;
    @(posedge clk); #1;
    chk("pulse_one_cycle", 64'(dr_s), 64'd0);
    chk("ready_again", 64'(rdy_s), 64'd1);
  endtask

  task automatic hold_seq(input int s);
    int base, c, k, n;
    logic [63:0] va, vb;
    logic [45:0] ad;
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    ad = 46'h2A_0000_0020;
    base = acc_count(s);
    @(negedge clk);
    sel = (s != 0);
    req_we = 1'b1; req_addr = ad; req_line = va; req = 1'b1;
    k = 0; c = 0; n = 0;
    while (c < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (dr_s) begin
        if (c == 1) chk("hold_read_first", lo_s, va);
        if (c == 3) chk("hold_read_second", lo_s, vb);
        c++;
      end
      if (acc_count(s) > base + k) begin
        k++;
        case (k)
          1: begin req_we = 1'b0; req_line = ~va; end
          2: begin req_we = 1'b1; req_line = vb; end
          3: begin req_we = 1'b0; req_line = ~vb; end
          default: begin req = 1'b0; req_line = 64'hBAD0_BAD0_BAD0_BAD0; end
        endcase
      end
    end
    req = 1'b0;
    chk("hold_all_completed", 64'(c), 64'd4);
    if (acc_count(s) >= base + 4) begin
      for (int i = 0; i < 3; i++)
        chk("accept_spacing", 64'(acc_at(s, base + i + 1) - acc_at(s, base + i)),
            (s != 0) ? 64'd3 : 64'd6);
    end else begin
      chk("hold_accept_count", 64'(acc_count(s) - base), 64'd4);
    end
    mem_m[key(s, ad)] = vb;
    lo_m[s] = vb;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] got;
    logic [45:0] a;

    tbl[0] = '{1'b0, 46'h005,           64'd0,                  64'd0};
    tbl[1] = '{1'b1, 46'h3FF,           64'hDEAD_BEEF_0123_4567, 64'd0};
    tbl[2] = '{1'b0, 46'h3FF,           64'd0,                  64'hDEAD_BEEF_0123_4567};
    tbl[3] = '{1'b1, 46'h001,           64'h1111,               64'hDEAD_BEEF_0123_4567};
    tbl[4] = '{1'b0, 46'h401,           64'd0,                  64'h1111};
    tbl[5] = '{1'b0, 46'h002,           64'd0,                  64'd0};
    tbl[6] = '{1'b0, 46'h1234_5678_9BFF, 64'd0,                 64'hDEAD_BEEF_0123_4567};

    reset = 1'b0; req = 1'b0; sel = 1'b0; req_we = 1'b0; req_addr = '0; req_line = '0;
    lo_m[0] = 64'd0; lo_m[1] = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", 64'(rr_a), 64'd1);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_dr_a", 64'(dr_a), 64'd0);
    chk("rst_line_a", lo_a, 64'd0);
    chk("rst_ready_b", 64'(rr_b), 64'd1);
    chk("rst_line_b", lo_b, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].line, got);
      chk("table_line_out", got, tbl[i].exp);
    end

    hold_seq(0);
    hold_seq(1);

    for (int i = 0; i < 60; i++) begin
      a = {14'($urandom), 32'($urandom)};
      a[9:0] = 10'($urandom_range(0, 7));
      do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, got);
    end

    do_req(0, 1'b1, 46'h7, 64'hCAFE_F00D_0000_0007, got);
    do_req(0, 1'b0, 46'h7, 64'd0, got);
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_addr = 46'h7; req_line = 64'h5555_AAAA_5555_AAAA; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_ready", 64'(rr_a), 64'd1);
    chk("midrst_dr", 64'(dr_a), 64'd0);
    chk("midrst_line", lo_a, 64'd0);
    mem_m.delete();
    lo_m[0] = 64'd0; lo_m[1] = 64'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_pulse", 64'(dr_a), 64'd0);
    end
    do_req(0, 1'b0, 46'h7, 64'd0, got);
    chk("midrst_read_invalid", got, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
